// File: rtl/rmii_pkg.sv
// Shared definitions for the RMII transceiver.
//   PREAMBLE_DIBIT / SFD_DIBIT : receive alignment patterns
//   tx_state_t / rx_state_t    : per-direction FSM states
package rmii_pkg;
  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT      = 2'b11;

  typedef enum logic       {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_PREAMBLE, RX_DATA} rx_state_t;
endpackage

// File: rtl/rmii_rate_gen.sv
// Restartable dibit strobe generator.
//   clk_i, rst_i : reference clock, async active-high reset
//   restart_i    : counter is 0 in the cycle after restart_i
//   fast_i       : 100 Mb/s, strobe every cycle
//   mid_i        : 0 = strobe on last cycle of a dibit period (TX tick),
//                  1 = strobe mid-period (RX sample point)
//   strobe_o     : tick / sample strobe
module rmii_rate_gen #(
  parameter int SLOW_DIV = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  input  logic fast_i,
  input  logic mid_i,
  output logic strobe_o
);
  localparam int CW = (SLOW_DIV > 2) ? $clog2(SLOW_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLOW_DIV - 1);
  localparam logic [CW-1:0] MID  = CW'(SLOW_DIV / 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign strobe_o = fast_i | (cnt_q == (mid_i ? MID : LAST));
endmodule

// File: rtl/rmii_xcvr.sv
// RMII transceiver: MAC beat stream <-> RMII dibits on the 50 MHz ref clock.
//   phy_ref_clk, reset       : sole clock, async active-high reset
//   speed_100                : 1 = 100 Mb/s, 0 = 10 Mb/s (latched while idle)
//   phy_txd/phy_tx_en        : transmit dibit + enable to PHY
//   phy_rxd/crs_dv/rx_er     : receive dibit, carrier/data valid, error
//   mac_txd/valid/last/ready : transmit beat handshake, LSB dibit first
//   mac_tx_underrun          : pulse when a non-last beat is not followed up
//   mac_rxd/valid/end/err    : receive beat strobe and end-of-frame status
//   mac_crs / mac_col        : registered carrier, combinational collision
module rmii_xcvr
  import rmii_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SLOW_DIV   = 10
) (
  input  logic                  phy_ref_clk,
  input  logic                  reset,
  input  logic                  speed_100,
  output logic [1:0]            phy_txd,
  output logic                  phy_tx_en,
  input  logic [1:0]            phy_rxd,
  input  logic                  phy_crs_dv,
  input  logic                  phy_rx_er,
  input  logic [DATA_WIDTH-1:0] mac_txd,
  input  logic                  mac_tx_valid,
  input  logic                  mac_tx_last,
  output logic                  mac_tx_ready,
  output logic                  mac_tx_underrun,
  output logic [DATA_WIDTH-1:0] mac_rxd,
  output logic                  mac_rx_valid,
  output logic                  mac_rx_end,
  output logic                  mac_rx_err,
  output logic                  mac_crs,
  output logic                  mac_col
);
  localparam int DPB = DATA_WIDTH / 2;
  localparam int CW  = (DPB > 1) ? $clog2(DPB) : 1;
  localparam logic [CW-1:0] LAST_DIB = CW'(DPB - 1);

  // ---------------- transmit ----------------
  tx_state_t             tx_state_q;
  logic [DATA_WIDTH-1:0] tx_sh_q;
  logic [1:0]            tx_txd_q;
  logic                  tx_en_q, tx_last_q, tx_urun_q, tx_fast_q;
  logic [CW-1:0]         tx_dib_q;
  logic                  tx_tick;

  rmii_rate_gen #(.SLOW_DIV(SLOW_DIV)) u_tx_rate (
    .clk_i(phy_ref_clk), .rst_i(reset),
    .restart_i(tx_state_q == TX_IDLE && mac_tx_valid),
    .fast_i(tx_fast_q), .mid_i(1'b0), .strobe_o(tx_tick));

  // Ready is decoded from state so a follow-on beat can be taken on the very
  // tick that retires the final dibit, keeping beats gapless.
  assign mac_tx_ready = (tx_state_q == TX_IDLE) ||
                        (tx_tick && tx_dib_q == LAST_DIB && !tx_last_q);

  always_ff @(posedge phy_ref_clk or posedge reset)
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '0;
      tx_txd_q   <= '0;
      tx_en_q    <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_urun_q  <= 1'b0;
      tx_fast_q  <= 1'b0;
      tx_dib_q   <= '0;
    end else begin
      tx_urun_q <= 1'b0;
      if (tx_state_q == TX_IDLE) tx_fast_q <= speed_100;
      if (mac_tx_valid && mac_tx_ready) begin
        tx_state_q <= TX_SHIFT;
        tx_txd_q   <= mac_txd[1:0];
        tx_sh_q    <= mac_txd >> 2;
        tx_last_q  <= mac_tx_last;
        tx_dib_q   <= '0;
        tx_en_q    <= 1'b1;
      end else if (tx_state_q == TX_SHIFT && tx_tick) begin
        if (tx_dib_q != LAST_DIB) begin
          tx_txd_q <= tx_sh_q[1:0];
          tx_sh_q  <= tx_sh_q >> 2;
          tx_dib_q <= tx_dib_q + CW'(1);
        end else begin
          // End of beat with nothing to follow: clean end or underrun.
          tx_state_q <= TX_IDLE;
          tx_en_q    <= 1'b0;
          tx_txd_q   <= '0;
          tx_urun_q  <= ~tx_last_q;
        end
      end
    end

  assign phy_txd         = tx_txd_q;
  assign phy_tx_en       = tx_en_q;
  assign mac_tx_underrun = tx_urun_q;
  assign mac_col         = tx_en_q & phy_crs_dv;

  // ---------------- receive ----------------
  rx_state_t             rx_state_q;
  logic                  rx_fast_q, rx_skip_q, rx_low_q, rx_bad_q;
  logic [CW-1:0]         rx_dib_q;
  logic [DATA_WIDTH-1:0] rx_acc_q;
  logic                  rx_valid_q, rx_end_q, rx_err_q, crs_q;
  logic                  rx_sample, rx_sfd;

  assign rx_sfd = rx_state_q == RX_PREAMBLE && phy_crs_dv && phy_rxd == SFD_DIBIT;

  rmii_rate_gen #(.SLOW_DIV(SLOW_DIV)) u_rx_rate (
    .clk_i(phy_ref_clk), .rst_i(reset), .restart_i(rx_sfd),
    .fast_i(rx_fast_q), .mid_i(1'b1), .strobe_o(rx_sample));

  always_ff @(posedge phy_ref_clk or posedge reset)
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_fast_q  <= 1'b0;
      rx_skip_q  <= 1'b0;
      rx_low_q   <= 1'b0;
      rx_bad_q   <= 1'b0;
      rx_dib_q   <= '0;
      rx_acc_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_end_q   <= 1'b0;
      rx_err_q   <= 1'b0;
      crs_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_end_q   <= 1'b0;
      rx_err_q   <= 1'b0;
      crs_q      <= phy_crs_dv;
      case (rx_state_q)
        RX_IDLE: begin
          rx_fast_q <= speed_100;
          if (phy_crs_dv && phy_rxd == PREAMBLE_DIBIT) rx_state_q <= RX_PREAMBLE;
        end
        RX_PREAMBLE: begin
          if (!phy_crs_dv) rx_state_q <= RX_IDLE;
          else if (phy_rxd == SFD_DIBIT) begin
            rx_state_q <= RX_DATA;
            rx_dib_q   <= '0;
            rx_bad_q   <= 1'b0;
            rx_low_q   <= 1'b0;
            // At 10 Mb/s the SFD is seen on its first repeat, so the first
            // mid-period sample still lands on the SFD and is dropped.
            rx_skip_q  <= ~rx_fast_q;
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            if (rx_skip_q) rx_skip_q <= 1'b0;
            else begin
              if (phy_rx_er) rx_bad_q <= 1'b1;
              if (!phy_crs_dv) begin
                // A lone low sample is the end-of-frame toggle; its dibit
                // is not data. The second consecutive low closes the frame.
                if (rx_low_q) begin
                  rx_end_q   <= 1'b1;
                  rx_err_q   <= rx_bad_q | phy_rx_er | (rx_dib_q != '0);
                  rx_state_q <= RX_IDLE;
                end
                rx_low_q <= 1'b1;
              end else begin
                rx_low_q <= 1'b0;
                rx_acc_q[{rx_dib_q, 1'b0} +: 2] <= phy_rxd;
                if (rx_dib_q == LAST_DIB) begin
                  rx_valid_q <= 1'b1;
                  rx_dib_q   <= '0;
                end else rx_dib_q <= rx_dib_q + CW'(1);
              end
            end
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end

  // The accumulator is complete during the valid cycle; the next beat's first
  // dibit lands at the end of that cycle at the earliest.
  assign mac_rxd      = rx_acc_q;
  assign mac_rx_valid = rx_valid_q;
  assign mac_rx_end   = rx_end_q;
  assign mac_rx_err   = rx_err_q;
  assign mac_crs      = crs_q;
endmodule

// File: tb/tb_rmii_xcvr.sv
module tb_rmii_xcvr;
  localparam int DW = 8, SDIV = 10, DPB = DW / 2;

  logic          clk = 1'b0, rst = 1'b1, speed_100 = 1'b1;
  logic [1:0]    phy_txd, phy_rxd;
  logic          phy_tx_en, phy_crs_dv, phy_rx_er;
  logic [DW-1:0] mac_txd, mac_rxd;
  logic          mac_tx_valid, mac_tx_last, mac_tx_ready, mac_tx_underrun;
  logic          mac_rx_valid, mac_rx_end, mac_rx_err, mac_crs, mac_col;

  rmii_xcvr #(.DATA_WIDTH(DW), .SLOW_DIV(SDIV)) dut (
    .phy_ref_clk(clk), .reset(rst), .speed_100(speed_100),
    .phy_txd(phy_txd), .phy_tx_en(phy_tx_en), .phy_rxd(phy_rxd),
    .phy_crs_dv(phy_crs_dv), .phy_rx_er(phy_rx_er),
    .mac_txd(mac_txd), .mac_tx_valid(mac_tx_valid), .mac_tx_last(mac_tx_last),
    .mac_tx_ready(mac_tx_ready), .mac_tx_underrun(mac_tx_underrun),
    .mac_rxd(mac_rxd), .mac_rx_valid(mac_rx_valid), .mac_rx_end(mac_rx_end),
    .mac_rx_err(mac_rx_err), .mac_crs(mac_crs), .mac_col(mac_col));

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // receive monitor
  logic [DW-1:0] rx_got[$];
  int rx_ends = 0, rx_errv = 0, rx_both = 0, first_v = -1;
  always @(negedge clk) begin
    if (mac_rx_valid) begin
      rx_got.push_back(mac_rxd);
      if (first_v < 0) first_v = cyc;
    end
    if (mac_rx_end) begin rx_ends++; rx_errv = int'(mac_rx_err); end
    if (mac_rx_valid && mac_rx_end) rx_both++;
  end

  // cycle table: inputs driven in a cycle, outputs expected in that cycle
  typedef struct packed {
    logic v; logic [7:0] d; logic l;
    logic [1:0] etxd; logic een; logic erdy; logic eur;
  } txv_t;
  txv_t tv[$];
  task automatic addv(input logic v, input logic [7:0] d, input logic l,
                      input logic [1:0] t, input logic e, input logic r, input logic u);
    txv_t x;
    x.v = v; x.d = d; x.l = l; x.etxd = t; x.een = e; x.erdy = r; x.eur = u;
    tv.push_back(x);
  endtask

  // Reference: the PHY line must carry every beat's dibits LSB-first, each
  // held one dibit period, contiguously, with tx_en high exactly that long.
  task automatic tx_frame(input bit spd, input int nb, input logic [DW-1:0] bt [4]);
    logic [1:0] expq[$];
    logic [1:0] got[$];
    logic [DW-1:0] b;
    int hold, sent, n, urun;
    hold = spd ? 1 : SDIV;
    for (int i = 0; i < nb; i++) begin
      b = bt[i];
      for (int d = 0; d < DPB; d++) begin
        repeat (hold) expq.push_back(b[1:0]);
        b = b >> 2;
      end
    end
    @(negedge clk);
    speed_100 = spd;
    sent = 0; n = 0; urun = 0;
    while (n < 3000) begin
      if (phy_tx_en) got.push_back(phy_txd);
      if (mac_tx_underrun) urun++;
      if (sent == nb && !phy_tx_en && got.size() > 0) break;
      if (sent > 0) speed_100 = ~spd;  // must be ignored mid-frame
      if (sent < nb && mac_tx_ready) begin
        mac_tx_valid = 1'b1; mac_txd = bt[sent]; mac_tx_last = (sent == nb - 1);
        sent++;
      end else begin
        mac_tx_valid = 1'b0; mac_tx_last = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk("tx_timeout", n < 3000, 1);
    chk("tx_len", got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      if (got[i] !== expq[i]) chk($sformatf("tx_dibit%0d", i), got[i], expq[i]);
    chk("tx_no_underrun", urun, 0);
    speed_100 = spd;
  endtask

  // Build an RMII line from preamble, SFD, data and trailing lows; expected
  // beats are the whole bytes, error = injected rx_er or leftover dibits.
  task automatic rx_frame(input bit spd, input int nby, input logic [DW-1:0] by [4],
                          input int tog, input int er, input int extra, input bit tim);
    logic [3:0] ln[$];  // {crs, er, dibit}
    logic [DW-1:0] b;
    int hold, ndib, sfd_c;
    hold = spd ? 1 : SDIV;
    for (int i = 0; i < 4; i++) ln.push_back(4'b1001);
    ln.push_back(4'b1011);
    ndib = 0;
    for (int i = 0; i < nby; i++) begin
      b = by[i];
      for (int d = 0; d < DPB; d++) begin
        if (ndib == tog) ln.push_back({2'b00, 2'($urandom)});
        ln.push_back({1'b1, ndib == er, b[1:0]});
        b = b >> 2;
        ndib++;
      end
    end
    for (int i = 0; i < extra; i++) begin
      ln.push_back({1'b1, ndib == er, 2'($urandom)});
      ndib++;
    end
    repeat (3) ln.push_back(4'b0000);
    rx_got.delete(); rx_ends = 0; rx_both = 0; first_v = -1; rx_errv = -1;
    sfd_c = -1;
    @(negedge clk);
    speed_100 = spd;
    for (int i = 0; i < ln.size(); i++)
      repeat (hold) begin
        if (i == 4 && sfd_c < 0) sfd_c = cyc;
        if (i == 5) speed_100 = ~spd;
        {phy_crs_dv, phy_rx_er, phy_rxd} = ln[i];
        @(negedge clk);
      end
    repeat (4) @(negedge clk);
    speed_100 = spd;
    chk("rx_nbeats", rx_got.size(), nby);
    for (int i = 0; i < nby && i < rx_got.size(); i++)
      chk($sformatf("rx_beat%0d", i), rx_got[i], by[i]);
    chk("rx_end_cnt", rx_ends, 1);
    chk("rx_err", rx_errv, ((er >= 0) || (extra != 0)) ? 1 : 0);
    chk("rx_valid_end_overlap", rx_both, 0);
    if (tim) chk("rx_latency", 32'(first_v - sfd_c), DPB + 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] bb[4];
    bit sp;
    int nb, tg, er;
    mac_txd = '0; mac_tx_valid = 0; mac_tx_last = 0;
    phy_rxd = '0; phy_crs_dv = 0; phy_rx_er = 0;

    repeat (3) @(negedge clk);
    chk("rst_tx_en", phy_tx_en, 0);
    chk("rst_txd", phy_txd, 0);
    chk("rst_urun", mac_tx_underrun, 0);
    chk("rst_rx_valid", mac_rx_valid, 0);
    chk("rst_rx_end", mac_rx_end, 0);
    chk("rst_rx_err", mac_rx_err, 0);
    chk("rst_crs", mac_crs, 0);
    chk("rst_rxd", mac_rxd, 0);
    rst = 0;

    // carrier sense latency
    @(negedge clk); phy_crs_dv = 1;
    chk("crs_before", mac_crs, 0);
    @(negedge clk); chk("crs_after", mac_crs, 1); phy_crs_dv = 0;
    @(negedge clk); chk("crs_drop", mac_crs, 0);

    // 3-beat gapless frame, then an underrun after a non-last beat
    addv(1, 8'h5D, 0, 2'b00, 0, 1, 0);
    addv(1, 8'hA0, 0, 2'b01, 1, 0, 0);
    addv(1, 8'hA0, 0, 2'b11, 1, 0, 0);
    addv(1, 8'hA0, 0, 2'b01, 1, 0, 0);
    addv(1, 8'hA0, 0, 2'b01, 1, 1, 0);
    addv(1, 8'hFF, 1, 2'b00, 1, 0, 0);
    addv(1, 8'hFF, 1, 2'b00, 1, 0, 0);
    addv(1, 8'hFF, 1, 2'b10, 1, 0, 0);
    addv(1, 8'hFF, 1, 2'b10, 1, 1, 0);
    for (int i = 0; i < 4; i++) addv(0, 8'h00, 0, 2'b11, 1, 0, 0);
    addv(0, 8'h00, 0, 2'b00, 0, 1, 0);
    addv(1, 8'h5D, 0, 2'b00, 0, 1, 0);
    addv(0, 8'h00, 0, 2'b01, 1, 0, 0);
    addv(0, 8'h00, 0, 2'b11, 1, 0, 0);
    addv(0, 8'h00, 0, 2'b01, 1, 0, 0);
    addv(0, 8'h00, 0, 2'b01, 1, 1, 0);
    addv(0, 8'h00, 0, 2'b00, 0, 1, 1);
    addv(0, 8'h00, 0, 2'b00, 0, 1, 0);
    speed_100 = 1;
    foreach (tv[i]) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_txd", i), phy_txd, tv[i].etxd);
      chk($sformatf("tbl%0d_en", i), phy_tx_en, tv[i].een);
      chk($sformatf("tbl%0d_rdy", i), mac_tx_ready, tv[i].erdy);
      chk($sformatf("tbl%0d_urun", i), mac_tx_underrun, tv[i].eur);
      mac_tx_valid = tv[i].v; mac_txd = tv[i].d; mac_tx_last = tv[i].l;
    end

    // 10 Mb/s receive of 0xD5
    bb[0] = 8'hD5; bb[1] = 0; bb[2] = 0; bb[3] = 0;
    rx_frame(0, 1, bb, -1, -1, 0, 0);
    // RMII toggle mid-frame must not end it
    bb[0] = 8'h12; bb[1] = 8'h34;
    rx_frame(1, 2, bb, 3, -1, 0, 0);
    // rx_er in data plus a 3-dibit partial beat
    bb[0] = 8'hA7;
    rx_frame(1, 1, bb, -1, 1, 3, 1);

    // asynchronous reset in the middle of a beat
    @(negedge clk); speed_100 = 1;
    mac_txd = 8'h3C; mac_tx_valid = 1; mac_tx_last = 0; phy_crs_dv = 1;
    @(negedge clk); mac_tx_valid = 0;
    @(negedge clk);
    chk("mid_txd", phy_txd, 2'b11);
    chk("mid_col", mac_col, 1);
    #3 rst = 1;
    #1;
    chk("async_rst_en", phy_tx_en, 0);
    chk("async_rst_txd", phy_txd, 0);
    @(negedge clk); rst = 0; phy_crs_dv = 0;
    bb[0] = 8'hC9;
    tx_frame(1, 1, bb);

    // randomized frames in both directions
    for (int k = 0; k < 6; k++) begin
      sp = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) bb[i] = DW'($urandom);
      tx_frame(sp, nb, bb);
    end
    for (int k = 0; k < 6; k++) begin
      sp = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) bb[i] = DW'($urandom);
      tg = $urandom_range(0, 1) ? -1 : $urandom_range(1, nb * DPB - 1);
      er = $urandom_range(0, 1) ? -1 : $urandom_range(0, nb * DPB - 1);
      rx_frame(sp, nb, bb, tg, er, $urandom_range(0, 3), sp && (tg < 0 || tg >= DPB));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
